pipe_e: RTL



---
 rtl/pipe_e_pkg.sv | 46 ++++
 rtl/pipe_e_if.sv | 44 ++++
 rtl/pipe_e_hazard_ld.sv | 18 +
 rtl/pipe_e.sv | 61 ++++++
 4 files changed

// File: rtl/pipe_e_pkg.sv
// Shared Y86 encodings and the E-stage register bundle used by the decode-to-execute pipeline register.
package pipe_e_pkg;

  localparam int BYTE = 8;
  localparam int WORD = 32;

  localparam logic [BYTE-1:0] INOP    = 8'h01;
  localparam logic [BYTE-1:0] IIRMOVL = 8'h03;
  localparam logic [BYTE-1:0] IMRMOVL = 8'h05;
  localparam logic [BYTE-1:0] IOPL    = 8'h06;
  localparam logic [BYTE-1:0] IPOPL   = 8'h0B;
  localparam logic [BYTE-1:0] FNONE   = 8'h00;
  localparam logic [BYTE-1:0] SBUB    = 8'h00;
  localparam logic [BYTE-1:0] SAOK    = 8'h01;
  localparam logic [BYTE-1:0] RNONE   = 8'h0F;

  typedef struct packed {
    logic [BYTE-1:0] stat;
    logic [BYTE-1:0] icode;
    logic [BYTE-1:0] ifun;
    logic [WORD-1:0] val_c;
    logic [WORD-1:0] val_a;
    logic [WORD-1:0] val_b;
    logic [BYTE-1:0] dst_e;
    logic [BYTE-1:0] dst_m;
    logic [BYTE-1:0] src_a;
    logic [BYTE-1:0] src_b;
  } e_regs_t;

  // A bubble is a nop that writes no register, so it can never create a hazard.
  function automatic e_regs_t bubble_regs();
    e_regs_t r;
    r.stat  = SBUB;
    r.icode = INOP;
    r.ifun  = FNONE;
    r.val_c = '0;
    r.val_a = '0;
    r.val_b = '0;
    r.dst_e = RNONE;
    r.dst_m = RNONE;
    r.src_a = RNONE;
    r.src_b = RNONE;
    return r;
  endfunction

endpackage

// File: rtl/pipe_e_if.sv
// Decode-to-execute bus: D/d fields and control in, E fields, hazard flag and bubble count out.
interface pipe_e_if #(parameter int CNT_W = 32);
  import pipe_e_pkg::*;

  logic            E_stall;
  logic            E_bubble_req;
  logic [BYTE-1:0] D_stat;
  logic [BYTE-1:0] D_icode;
  logic [BYTE-1:0] D_ifun;
  logic [WORD-1:0] D_valC;
  logic [WORD-1:0] d_valA;
  logic [WORD-1:0] d_valB;
  logic [BYTE-1:0] d_dstE;
  logic [BYTE-1:0] d_dstM;
  logic [BYTE-1:0] d_srcA;
  logic [BYTE-1:0] d_srcB;

  logic [BYTE-1:0] E_stat;
  logic [BYTE-1:0] E_icode;
  logic [BYTE-1:0] E_ifun;
  logic [WORD-1:0] E_valC;
  logic [WORD-1:0] E_valA;
  logic [WORD-1:0] E_valB;
  logic [BYTE-1:0] E_dstE;
  logic [BYTE-1:0] E_dstM;
  logic [BYTE-1:0] E_srcA;
  logic [BYTE-1:0] E_srcB;
  logic            load_use;
  logic [CNT_W-1:0] bubble_cnt;

  modport master (
    output E_stall, E_bubble_req, D_stat, D_icode, D_ifun, D_valC,
           d_valA, d_valB, d_dstE, d_dstM, d_srcA, d_srcB,
    input  E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
           E_dstE, E_dstM, E_srcA, E_srcB, load_use, bubble_cnt
  );

  modport slave (
    input  E_stall, E_bubble_req, D_stat, D_icode, D_ifun, D_valC,
           d_valA, d_valB, d_dstE, d_dstM, d_srcA, d_srcB,
    output E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
           E_dstE, E_dstM, E_srcA, E_srcB, load_use, bubble_cnt
  );
endinterface

// File: rtl/pipe_e_hazard_ld.sv
// Load/use hazard detect: a load in E whose destination is read by the instruction in D.
module pipe_e_hazard_ld
  import pipe_e_pkg::*;
(
  input  logic [BYTE-1:0] E_icode,
  input  logic [BYTE-1:0] E_dstM,
  input  logic [BYTE-1:0] d_srcA,
  input  logic [BYTE-1:0] d_srcB,
  output logic            load_use
);

  logic is_load;

  assign is_load  = (E_icode == IMRMOVL) || (E_icode == IPOPL);
  assign load_use = is_load && (E_dstM != RNONE) &&
                    ((E_dstM == d_srcA) || (E_dstM == d_srcB));

endmodule

// File: rtl/pipe_e.sv
// E-stage pipeline register with stall/bubble control, load/use detection and a saturating bubble counter.
module pipe_e
  import pipe_e_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic    clk,
  input logic    rst,
  pipe_e_if.slave bus
);

  e_regs_t        e_q;
  e_regs_t        d_in;
  logic [CNT_W-1:0] cnt_q;
  logic           load_use;
  logic           bub;

  assign d_in = '{stat:  bus.D_stat,  icode: bus.D_icode, ifun:  bus.D_ifun,
                  val_c: bus.D_valC,  val_a: bus.d_valA,  val_b: bus.d_valB,
                  dst_e: bus.d_dstE,  dst_m: bus.d_dstM,
                  src_a: bus.d_srcA,  src_b: bus.d_srcB};

  pipe_e_hazard_ld u_hazard_ld (
    .E_icode  (e_q.icode),
    .E_dstM   (e_q.dst_m),
    .d_srcA   (bus.d_srcA),
    .d_srcB   (bus.d_srcB),
    .load_use (load_use)
  );

  assign bub = bus.E_bubble_req | load_use;

  // Stall outranks bubble: a held load keeps its hazard alive until the stall drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_q   <= bubble_regs();
      cnt_q <= '0;
    end else if (!bus.E_stall) begin
      if (bub) begin
        e_q <= bubble_regs();
        if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + CNT_W'(1);
      end else begin
        e_q <= d_in;
      end
    end
  end

  assign bus.E_stat     = e_q.stat;
  assign bus.E_icode    = e_q.icode;
  assign bus.E_ifun     = e_q.ifun;
  assign bus.E_valC     = e_q.val_c;
  assign bus.E_valA     = e_q.val_a;
  assign bus.E_valB     = e_q.val_b;
  assign bus.E_dstE     = e_q.dst_e;
  assign bus.E_dstM     = e_q.dst_m;
  assign bus.E_srcA     = e_q.src_a;
  assign bus.E_srcB     = e_q.src_b;
  assign bus.load_use   = load_use;
  assign bus.bubble_cnt = cnt_q;

endmodule
